dcache_ctrl: RTL and testbench

DCACHE_CTRL -- requirements
Module: dcache_ctrl

---
 rtl/dcache_ctrl_pkg.sv | 17 +
 rtl/dcache_sram.sv | 51 +++++
 rtl/dcache_ctrl.sv | 137 +++++++++++++
 tb/tb_dcache_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_ctrl_pkg.sv
// Shared definitions for the direct-mapped data cache controller.
//   TAG_W / INDEX_W / LINE_W / NUM_LINES : cache geometry
//   state_e                              : controller state enumeration
package dcache_ctrl_pkg;

  localparam int unsigned TAG_W     = 22;
  localparam int unsigned INDEX_W   = 5;
  localparam int unsigned LINE_W    = 256;
  localparam int unsigned NUM_LINES = 32;

  typedef enum logic [1:0] {
    StIdle,
    StWriteback,
    StAllocate
  } state_e;

endpackage

// File: rtl/dcache_sram.sv
// Cache storage: valid/dirty bits, tag array and line data array.
//   clk, reset                          : clock, synchronous active-high reset (clears valid/dirty)
//   rd_index -> rd_valid/dirty/tag/data : asynchronous read port
//   wr_en, wr_index, wr_dirty,
//   wr_tag, wr_data                     : write port; a write always leaves the line valid
module dcache_sram
  import dcache_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic               rd_dirty,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [LINE_W-1:0]  rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic               wr_dirty,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [LINE_W-1:0]  wr_data
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
      dirty_q[wr_index] <= wr_dirty;
    end
  end

  // Tag and data contents are left undefined by reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller (32 x 256-bit lines).
//   cpu_req/we/addr/wdata -> cpu_rdata, Stall : MEM-stage access and pipeline hold
//   mem_enable/write/addr/wdata, mem_rdata/ack : line transfer handshake with memory
//   hit_count, miss_count                      : access statistics
module dcache_ctrl
  import dcache_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              Stall,
  output logic              mem_enable,
  output logic              mem_write,
  output logic [31:0]       mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  logic [TAG_W-1:0]   addr_tag;
  logic [INDEX_W-1:0] addr_index;
  logic [2:0]         addr_word;
  logic               unused_byte_bits;

  assign addr_tag         = cpu_addr[31:10];
  assign addr_index       = cpu_addr[9:5];
  assign addr_word        = cpu_addr[4:2];
  assign unused_byte_bits = ^cpu_addr[1:0];

  logic              rd_valid, rd_dirty;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_data;
  logic              wr_en, wr_dirty;
  logic [LINE_W-1:0] wr_data;
  logic [LINE_W-1:0] store_line;
  logic              hit, miss_start;

  state_e      state_q, state_d;
  logic [31:0] hit_count_q, miss_count_q;

  // Read and write share the CPU index: the pipeline holds cpu_addr while stalled,
  // so the line being written back or refilled is always the one addressed.
  dcache_sram u_sram (
    .clk      (clk),
    .reset    (reset),
    .rd_index (addr_index),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_index (addr_index),
    .wr_dirty (wr_dirty),
    .wr_tag   (addr_tag),
    .wr_data  (wr_data)
  );

  assign hit       = cpu_req & rd_valid & (rd_tag == addr_tag);
  assign cpu_rdata = rd_data[{addr_word, 5'b0} +: 32];
  assign mem_wdata = rd_data;
  assign Stall     = ~reset & ((state_q != StIdle) | (cpu_req & ~hit));

  always_comb begin
    store_line                          = rd_data;
    store_line[{addr_word, 5'b0} +: 32] = cpu_wdata;
  end

  always_comb begin
    state_d    = state_q;
    wr_en      = 1'b0;
    wr_dirty   = 1'b0;
    wr_data    = store_line;
    mem_enable = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = {addr_tag, addr_index, 5'b0};
    miss_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cpu_req) begin
          if (hit) begin
            if (cpu_we) begin
              wr_en    = 1'b1;
              wr_dirty = 1'b1;
            end
          end else begin
            miss_start = 1'b1;
            state_d    = (rd_valid & rd_dirty) ? StWriteback : StAllocate;
          end
        end
      end
      StWriteback: begin
        mem_enable = 1'b1;
        mem_write  = 1'b1;
        mem_addr   = {rd_tag, addr_index, 5'b0};
        if (mem_ack) state_d = StAllocate;
      end
      StAllocate: begin
        mem_enable = 1'b1;
        if (mem_ack) begin
          wr_en   = 1'b1;
          wr_data = mem_rdata;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // A transfer caught by reset is abandoned immediately.
    if (reset) begin
      wr_en      = 1'b0;
      mem_enable = 1'b0;
      mem_write  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q <= state_d;
      // The replay after a refill completes with Stall=0 and so counts as a hit.
      if (cpu_req & ~Stall) hit_count_q  <= hit_count_q + 32'd1;
      if (miss_start)       miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed vector table, hand-written reset and
// stray-ack sequences, then random accesses against an architectural memory model.
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_req, cpu_we;
  logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
  logic         Stall, mem_enable, mem_write, mem_ack;
  logic [31:0]  mem_addr, hit_count, miss_count;
  logic [255:0] mem_wdata, mem_rdata;

  dcache_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .Stall      (Stall),
    .mem_enable (mem_enable),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Architectural memory (what a load must return), keyed by word address.
  logic [31:0]  ref_mem [int unsigned];
  // Backing memory served to the DUT, keyed by line address.
  logic [255:0] bmem [int unsigned];
  // Cache occupancy model: which line holds which tag, and whether it is modified.
  bit           m_valid [32];
  bit           m_dirty [32];
  logic [21:0]  m_tag   [32];
  int unsigned  exp_hit, exp_miss;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    bit          exp_miss;
    bit          exp_wb;
    logic [31:0] exp_rdata;
    int unsigned exp_hits;
    int unsigned exp_misses;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] wa);
    return (wa * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] wa;
    wa = a >> 2;
    if (ref_mem.exists(wa)) return ref_mem[wa];
    return init_word(wa);
  endfunction

  function automatic logic [255:0] ref_line(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = ref_word(la + 32'(w * 4));
    return l;
  endfunction

  function automatic logic [255:0] bmem_line(input logic [31:0] ln);
    logic [255:0] l;
    if (bmem.exists(ln)) return bmem[ln];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word((ln << 3) + 32'(w));
    return l;
  endfunction

  task automatic preset(input logic [31:0] addr, input logic [31:0] val);
    logic [255:0] l;
    ref_mem[addr >> 2] = val;
    l = bmem_line(addr >> 5);
    l[{addr[4:2], 5'b0} +: 32] = val;
    bmem[addr >> 5] = l;
  endtask

  // Reset discards the cache: modified data never reached memory, so the
  // architectural view of those lines falls back to the backing memory.
  task automatic model_reset();
    logic [31:0]  la;
    logic [255:0] bl;
    for (int i = 0; i < 32; i++) begin
      if (m_valid[i] && m_dirty[i]) begin
        la = {m_tag[i], 5'(i), 5'b0};
        bl = bmem_line(la >> 5);
        for (int w = 0; w < 8; w++) ref_mem[(la >> 2) + 32'(w)] = bl[w*32 +: 32];
      end
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    exp_hit  = 0;
    exp_miss = 0;
  endtask

  // One CPU access held until Stall drops, serving memory with the given ack delay.
  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                        input int delay, output bit first_stall, output bit saw_wb,
                        output logic [31:0] rdata);
    int           idx, waited;
    logic [21:0]  tg;
    bit           exp_m, exp_w, saw_al, in_x, stable, done;
    logic [31:0]  cap_addr;
    logic         cap_wr;
    logic [255:0] cap_wd;
    idx    = int'(addr[9:5]);
    tg     = addr[31:10];
    exp_m  = !(m_valid[idx] && m_tag[idx] == tg);
    exp_w  = exp_m && m_valid[idx] && m_dirty[idx];
    first_stall = 1'b0;
    saw_wb = 1'b0;
    rdata  = '0;
    saw_al = 1'b0;
    in_x   = 1'b0;
    stable = 1'b1;
    done   = 1'b0;
    waited = 0;
    cap_addr = '0;
    cap_wr   = 1'b0;
    cap_wd   = '0;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wd;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      #1;
      if (cyc == 0) first_stall = Stall;
      if (!Stall) begin
        done  = 1'b1;
        rdata = cpu_rdata;
        chk("mem_enable_low_on_completion", mem_enable, 1'b0);
      end else if (mem_enable) begin
        if (!in_x) begin
          in_x = 1'b1; waited = 0; stable = 1'b1;
          cap_addr = mem_addr; cap_wr = mem_write; cap_wd = mem_wdata;
          if (mem_write) begin
            saw_wb = 1'b1;
            chk("wb_addr", mem_addr, {m_tag[idx], addr[9:5], 5'b0});
            chk("wb_data", mem_wdata, ref_line({m_tag[idx], addr[9:5], 5'b0}));
          end else begin
            saw_al = 1'b1;
            chk("alloc_addr", mem_addr, {addr[31:5], 5'b0});
          end
        end else if (mem_addr !== cap_addr || mem_write !== cap_wr ||
                     (cap_wr && mem_wdata !== cap_wd)) begin
          stable = 1'b0;
        end
        if (waited == delay) begin
          chk("mem_stable_while_enabled", stable, 1'b1);
          if (cap_wr) bmem[cap_addr >> 5] = mem_wdata;
          else mem_rdata = bmem_line(cap_addr >> 5);
          mem_ack = 1'b1;
          in_x    = 1'b0;
        end
        waited++;
      end
      @(posedge clk);
      @(negedge clk);
      mem_ack = 1'b0;
    end
    cpu_req = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL access_timeout addr=%h actual=stalled required=complete", addr);
      return;
    end
    chk("first_cycle_stall", first_stall, exp_m);
    chk("writeback_seen", saw_wb, exp_w);
    chk("allocate_seen", saw_al, exp_m);
    if (!we) chk("load_data", rdata, ref_word(addr));
    if (exp_m) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_dirty[idx] = 1'b0;
      exp_miss++;
    end
    if (we) begin
      ref_mem[addr >> 2] = wd;
      m_dirty[idx] = 1'b1;
    end
    exp_hit++;
    #1;
    chk("hit_count", hit_count, exp_hit);
    chk("miss_count", miss_count, exp_miss);
  endtask

  task automatic stray_ack();
    logic [31:0] h, m;
    h = hit_count;
    m = miss_count;
    cpu_req   = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = {8{$urandom()}};
    #1;
    chk("stray_stall", Stall, 1'b0);
    chk("stray_mem_enable", mem_enable, 1'b0);
    @(posedge clk);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("stray_hit_count", hit_count, exp_hit);
    chk("stray_miss_count", miss_count, exp_miss);
    chk("stray_mem_enable_after", mem_enable, 1'b0);
    if (h != hit_count || m != miss_count) begin
      checks++;
      failures++;
      $display("FAIL stray_counter_change actual=%0d/%0d required=%0d/%0d",
               hit_count, miss_count, h, m);
    end
  endtask

  initial begin
    bit          fs, wb, found;
    logic [31:0] rd;

    vecs[0] = '{0, 32'h0000_0004, 32'h0,         2,  1, 0, 32'hDEAD_BEEF, 1, 1};
    vecs[1] = '{1, 32'h0000_0008, 32'h1234_5678, 0,  0, 0, 32'h0,         2, 1};
    vecs[2] = '{0, 32'h0000_0008, 32'h0,         0,  0, 0, 32'h1234_5678, 3, 1};
    vecs[3] = '{0, 32'h0000_0408, 32'h0,         10, 1, 1, 32'hCAFE_F00D, 4, 2};
    vecs[4] = '{0, 32'h0000_0004, 32'h0,         1,  1, 0, 32'hDEAD_BEEF, 5, 3};
    vecs[5] = '{0, 32'h0000_0008, 32'h0,         0,  0, 0, 32'h1234_5678, 6, 3};

    preset(32'h0000_0004, 32'hDEAD_BEEF);
    preset(32'h0000_0408, 32'hCAFE_F00D);
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = '0;
    end
    exp_hit  = 0;
    exp_miss = 0;

    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("stall_during_reset", Stall, 1'b0);
    reset = 1'b0;
    #1;
    chk("reset_stall", Stall, 1'b0);
    chk("reset_mem_enable", mem_enable, 1'b0);
    chk("reset_mem_write", mem_write, 1'b0);
    chk("reset_hit_count", hit_count, 32'd0);
    chk("reset_miss_count", miss_count, 32'd0);

    for (int v = 0; v < 6; v++) begin
      access(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].delay, fs, wb, rd);
      chk($sformatf("vec%0d_miss", v), fs, vecs[v].exp_miss);
      chk($sformatf("vec%0d_writeback", v), wb, vecs[v].exp_wb);
      if (!vecs[v].we) chk($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rdata);
      chk($sformatf("vec%0d_hits", v), hit_count, vecs[v].exp_hits);
      chk($sformatf("vec%0d_misses", v), miss_count, vecs[v].exp_misses);
    end

    // Reset in the middle of a refill, followed by a late ack.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_1000;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      #1;
      if (mem_enable && !mem_write) found = 1'b1;
      else begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    chk("rst_alloc_reached", found, 1'b1);
    chk("rst_alloc_addr", mem_addr, 32'h0000_1000);
    reset = 1'b1;
    #1;
    chk("rst_stall_in_reset", Stall, 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; cpu_req = 1'b0; mem_ack = 1'b1; mem_rdata = {8{32'hFFFF_FFFF}};
    #1;
    chk("rst_mem_enable", mem_enable, 1'b0);
    chk("rst_stall", Stall, 1'b0);
    chk("rst_miss_count", miss_count, 32'd0);
    @(posedge clk);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("rst_late_ack_mem_enable", mem_enable, 1'b0);
    chk("rst_late_ack_hit_count", hit_count, 32'd0);
    model_reset();
    access(1'b0, 32'h0000_1000, 32'h0, 1, fs, wb, rd);
    chk("rst_remiss", fs, 1'b1);

    // Stray ack while idle must not disturb the cached line or the counters.
    stray_ack();
    access(1'b0, 32'h0000_1000, 32'h0, 0, fs, wb, rd);
    chk("stray_still_hits", fs, 1'b0);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      a = (32'($urandom_range(0, 1)) << 31) | (32'($urandom_range(0, 3)) << 10) |
          (32'($urandom_range(0, 7)) << 5) | (32'($urandom_range(0, 7)) << 2);
      access(1'($urandom_range(0, 1)), a, $urandom(), int'($urandom_range(0, 3)), fs, wb, rd);
      if (n % 16 == 15) stray_ack();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
